array_sequencer: RTL and testbench
==================================

ARRAY_SEQUENCER -- requirements
Module: array_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, meaning PE array dimension (N x N).
REQ-002 SHALL have parameter NUM_BITS, default 8, meaning operand/result width of the array datapath.
REQ-003 SHALL have parameter KW, default 4, meaning width of the inner-dimension length field.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start_i  input  1  request to run one N x N tile of length k_len_i.
REQ-007 SHALL have port k_len_i  input  KW  inner-dimension length K; sampled when start is accepted.
REQ-008 SHALL have port abort_i  input  1  synchronous cancel of the current tile.
REQ-009 SHALL have port ready_o  output  1  high only in IDLE; start accepted when start_i & ready_o & k_len_i != 0.
REQ-010 SHALL have port feed_row_o  output  N  bit i enables the row-i operand source to present its next A element.
REQ-011 SHALL have port feed_col_o  output  N  bit j enables the column-j operand source to present its next B element.
REQ-012 SHALL have port mux_o  output  2*N*N  per-PE mode; PE(i,j) field at bit offset ((N-1-i)*N + (N-1-j))*2.
REQ-013 SHALL have port add_zero_o  output  N*N  per-PE clear of the partial sum; PE(i,j) at bit (N-1-i)*N + (N-1-j).
REQ-014 SHALL have port acc_valid_o  output  N  bit c qualifies the result leaving column c into its accumulator.
REQ-015 SHALL have port done_o  output  1  one-cycle pulse when a tile completes normally.

Function
REQ-016 SHALL encode mux fields: 00 hold, 01 MAC-and-forward, 10 forward-only, 11 unload-shift.
REQ-017 SHALL implement FSM IDLE -> STREAM -> UNLOAD -> DONE -> IDLE.
REQ-018 SHALL, on acceptance at edge 0, latch K and enter STREAM; STREAM occupies cycles t = 0 .. K+2(N-1)-1 (stream counter t, 5 bits for defaults).
REQ-019 SHALL in STREAM drive mux field of PE(i,j) to 01 when i+j <= t <= i+j+K-1, else 10.
REQ-020 SHALL assert add_zero_o for PE(i,j) only at t = i+j (first MAC cycle of that PE).
REQ-021 SHALL assert feed_row_o[i] for i <= t <= i+K-1 and feed_col_o[j] for j <= t <= j+K-1; both low otherwise.
REQ-022 SHALL in UNLOAD run N cycles with all mux fields 11 and acc_valid_o all ones; acc_valid_o zero in every other state.
REQ-023 SHALL in DONE drive done_o = 1, all mux fields 00, and return to IDLE the next cycle.
REQ-024 SHALL drive all mux fields 00, add_zero_o, feed_row_o, feed_col_o zero in IDLE.
REQ-025 SHALL give done_o exactly K + 2(N-1) + N + 1 cycles after the acceptance edge (K+11 for N=4).
REQ-026 SHALL ignore start_i when ready_o = 0 and when k_len_i = 0 (remain IDLE, no pulse).
REQ-027 SHALL, on abort_i high in STREAM, UNLOAD or DONE, enter IDLE at the next edge with all outputs at reset values and no done_o pulse; abort_i in IDLE has no effect.
REQ-028 SHALL give abort_i priority over start_i if both high in the same cycle while IDLE is being re-entered.
REQ-029 SHALL generate all outputs from registered state only (no combinational path from start_i or abort_i to outputs).

Reset
REQ-030 SHALL on rst_i low force, asynchronously, state IDLE, counters 0, ready_o = 1, all other outputs 0.
REQ-031 SHALL, on reset asserted mid-tile, discard the tile entirely; first accepted start after release runs a full tile.

Verification
REQ-032 SHALL cover K=1, N=4: start -> PE(0,0) mux 01 and add_zero at t=0 only, PE(3,3) at t=6 only, done_o at cycle 12.
REQ-033 SHALL cover K=4: feed_row_o[2] high t=2..5; acc_valid_o = 1111 for 4 cycles at cycles 11..14; done_o at cycle 15.
REQ-034 SHALL cover K=15 (max): STREAM 21 cycles, done_o at cycle 26, counter no wrap.
REQ-035 SHALL cover start_i held high during busy and start with k_len_i=0: no second tile, no extra done_o.
REQ-036 SHALL cover abort_i at t=3 of K=4: next cycle IDLE, ready_o=1, mux_o=0, done_o never pulses.
REQ-037 SHALL cover rst_i low in UNLOAD: outputs reset immediately without clock edge; next start yields done_o at K+11.

Source files
------------

// File: rtl/array_sequencer.sv
// Control sequencer for an N x N systolic array: streams one tile of inner length K,
// unloads the results, then pulses done.
module array_sequencer #(
   parameter int unsigned N        = 4,
   parameter int unsigned NUM_BITS = 8,
   parameter int unsigned KW       = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [KW-1:0]        k_len_i,
   input  logic                 abort_i,
   output logic                 ready_o,
   output logic [N-1:0]         feed_row_o,
   output logic [N-1:0]         feed_col_o,
   output logic [2*N*N-1:0]     mux_o,
   output logic [N*N-1:0]       add_zero_o,
   output logic [N-1:0]         acc_valid_o,
   output logic                 done_o
);

   // Counter spans the longest stream phase; datapath width has no bearing on sequencing.
   localparam int unsigned TW = $clog2((1 << KW) + 2 * N) + ((NUM_BITS > 0) ? 0 : 1);

   localparam logic [1:0] MuxHold   = 2'b00;
   localparam logic [1:0] MuxMac    = 2'b01;
   localparam logic [1:0] MuxFwd    = 2'b10;
   localparam logic [1:0] MuxUnload = 2'b11;

   typedef enum logic [1:0] {StIdle, StStream, StUnload, StDone} state_e;

   state_e          r_state, w_state_d;
   logic [TW-1:0]   r_t, w_t_d;
   logic [KW-1:0]   r_k, w_k_d;
   int unsigned     w_t, w_k;

   assign w_t = 32'(r_t);
   assign w_k = 32'(r_k);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= StIdle;
         r_t     <= '0;
         r_k     <= '0;
      end else begin
         r_state <= w_state_d;
         r_t     <= w_t_d;
         r_k     <= w_k_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_t_d     = r_t;
      w_k_d     = r_k;
      unique case (r_state)
         StIdle: begin
            if (start_i && (k_len_i != '0)) begin
               w_state_d = StStream;
               w_t_d     = '0;
               w_k_d     = k_len_i;
            end
         end
         StStream: begin
            if (abort_i) begin
               w_state_d = StIdle;
               w_t_d     = '0;
            end else if (w_t == w_k + 2 * N - 3) begin
               w_state_d = StUnload;
               w_t_d     = '0;
            end else begin
               w_t_d = r_t + TW'(1);
            end
         end
         StUnload: begin
            if (abort_i) begin
               w_state_d = StIdle;
               w_t_d     = '0;
            end else if (w_t == N - 1) begin
               w_state_d = StDone;
               w_t_d     = '0;
            end else begin
               w_t_d = r_t + TW'(1);
            end
         end
         StDone: begin
            w_state_d = StIdle;
            w_t_d     = '0;
         end
         default: begin
            w_state_d = StIdle;
            w_t_d     = '0;
         end
      endcase
   end

   // Outputs decode only registered state, so start/abort never reach them combinationally.
   always_comb begin
      ready_o     = (r_state == StIdle);
      feed_row_o  = '0;
      feed_col_o  = '0;
      mux_o       = '0;
      add_zero_o  = '0;
      acc_valid_o = '0;
      done_o      = 1'b0;
      unique case (r_state)
         StStream: begin
            for (int unsigned i = 0; i < N; i++) begin
               feed_row_o[i] = (w_t >= i) && (w_t <= i + w_k - 1);
               feed_col_o[i] = (w_t >= i) && (w_t <= i + w_k - 1);
               for (int unsigned j = 0; j < N; j++) begin
                  if ((w_t >= i + j) && (w_t <= i + j + w_k - 1)) begin
                     mux_o[((N-1-i)*N + (N-1-j))*2 +: 2] = MuxMac;
                  end else begin
                     mux_o[((N-1-i)*N + (N-1-j))*2 +: 2] = MuxFwd;
                  end
                  add_zero_o[(N-1-i)*N + (N-1-j)] = (w_t == i + j);
               end
            end
         end
         StUnload: begin
            for (int unsigned p = 0; p < N * N; p++) begin
               mux_o[p*2 +: 2] = MuxUnload;
            end
            acc_valid_o = '1;
         end
         StDone: begin
            for (int unsigned p = 0; p < N * N; p++) begin
               mux_o[p*2 +: 2] = MuxHold;
            end
            done_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_array_sequencer.sv
// Directed bench for array_sequencer (N=4): stream windows, unload, done timing,
// start filtering, abort and asynchronous reset.
module tb_array_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [3:0]  k_len_i;
   logic        abort_i;
   logic        ready_o;
   logic [3:0]  feed_row_o;
   logic [3:0]  feed_col_o;
   logic [31:0] mux_o;
   logic [15:0] add_zero_o;
   logic [3:0]  acc_valid_o;
   logic        done_o;

   int n_cmp = 0;
   int n_err = 0;
   int pulses;

   array_sequencer #(.N(4), .NUM_BITS(8), .KW(4)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .k_len_i     (k_len_i),
      .abort_i     (abort_i),
      .ready_o     (ready_o),
      .feed_row_o  (feed_row_o),
      .feed_col_o  (feed_col_o),
      .mux_o       (mux_o),
      .add_zero_o  (add_zero_o),
      .acc_valid_o (acc_valid_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   // Called at a negedge in IDLE; returns at the negedge after the acceptance edge (t = 0).
   task automatic start_tile(input logic [3:0] k);
      start_i = 1'b1;
      k_len_i = k;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_steps);
      int n;
      n = 0;
      while (!done_o && n < 64) begin
         step(1);
         n++;
      end
      check(tag, 64'(n), 64'(exp_steps));
   endtask

   initial begin
      rst_i   = 1'b0;
      start_i = 1'b0;
      k_len_i = 4'd0;
      abort_i = 1'b0;
      #2;
      check("rst_ready", 64'(ready_o), 64'd1);
      check("rst_mux", 64'(mux_o), 64'd0);
      check("rst_outs", {add_zero_o, feed_row_o, feed_col_o, acc_valid_o, done_o}, 64'd0);
      step(2);
      rst_i = 1'b1;
      step(1);

      // K=1
      start_tile(4'd1);
      check("k1_t0_mux", 64'(mux_o), 64'h6AAA_AAAA);
      check("k1_t0_az", 64'(add_zero_o), 64'h8000);
      check("k1_t0_feed", {feed_row_o, feed_col_o}, 64'h11);
      check("k1_t0_ready", 64'(ready_o), 64'd0);
      step(1);
      check("k1_t1_mux", 64'(mux_o), 64'h9A6A_AAAA);
      check("k1_t1_az", 64'(add_zero_o), 64'h4800);
      check("k1_t1_feed", {feed_row_o, feed_col_o}, 64'h22);
      step(5);
      check("k1_t6_mux", 64'(mux_o), 64'hAAAA_AAA9);
      check("k1_t6_az", 64'(add_zero_o), 64'h0001);
      for (int c = 0; c < 4; c++) begin
         step(1);
         check("k1_unload_mux", 64'(mux_o), 64'hFFFF_FFFF);
         check("k1_unload_acc", 64'(acc_valid_o), 64'hF);
      end
      step(1);
      check("k1_done", {done_o, mux_o}, {31'd0, 1'b1, 32'd0});
      step(1);
      check("k1_idle", {done_o, ready_o}, 64'b01);

      // K=4
      start_tile(4'd4);
      check("k4_t0_row", 64'(feed_row_o), 64'b0001);
      step(2);
      check("k4_t2_row", 64'(feed_row_o), 64'b0111);
      check("k4_t2_col", 64'(feed_col_o), 64'b0111);
      step(3);
      check("k4_t5_row", 64'(feed_row_o), 64'b1100);
      step(1);
      check("k4_t6_row", 64'(feed_row_o), 64'b1000);
      check("k4_t6_acc", 64'(acc_valid_o), 64'd0);
      step(4);
      for (int c = 0; c < 4; c++) begin
         check("k4_acc", {done_o, acc_valid_o}, 64'h0F);
         step(1);
      end
      check("k4_done", {done_o, acc_valid_o}, 64'h10);
      step(1);
      check("k4_idle", {done_o, ready_o}, 64'b01);

      // K=15: longest stream, counter must not wrap
      start_tile(4'd15);
      step(20);
      check("k15_t20_pe33", 64'(mux_o[1:0]), 64'b01);
      check("k15_t20_acc", 64'(acc_valid_o), 64'd0);
      step(1);
      check("k15_unload", 64'(acc_valid_o), 64'hF);
      step(4);
      check("k15_done", 64'(done_o), 64'd1);
      step(1);
      check("k15_idle", {done_o, ready_o}, 64'b01);

      // start held high through a busy tile
      start_i = 1'b1;
      k_len_i = 4'd2;
      step(1);
      check("held_busy", 64'(ready_o), 64'd0);
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         step(1);
         if (done_o) pulses++;
      end
      start_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step(1);
         if (done_o) pulses++;
      end
      check("held_pulses", 64'(pulses), 64'd1);
      check("held_ready", 64'(ready_o), 64'd1);

      // zero-length start is ignored
      start_i = 1'b1;
      k_len_i = 4'd0;
      step(3);
      check("k0_ready", 64'(ready_o), 64'd1);
      check("k0_outs", {mux_o, feed_row_o, done_o}, 64'd0);
      start_i = 1'b0;

      // abort at t=3 of K=4
      start_tile(4'd4);
      step(3);
      abort_i = 1'b1;
      step(1);
      abort_i = 1'b0;
      check("abort_ready", 64'(ready_o), 64'd1);
      check("abort_outs", {mux_o, add_zero_o, feed_row_o, feed_col_o}, 64'd0);
      pulses = 0;
      for (int c = 0; c < 16; c++) begin
         step(1);
         if (done_o) pulses++;
      end
      check("abort_no_done", 64'(pulses), 64'd0);

      // asynchronous reset during unload, then a full tile
      start_tile(4'd4);
      step(11);
      check("rstu_unload", 64'(acc_valid_o), 64'hF);
      #2;
      rst_i = 1'b0;
      #1;
      check("rstu_ready", 64'(ready_o), 64'd1);
      check("rstu_outs", {mux_o, acc_valid_o, done_o}, 64'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      start_tile(4'd4);
      wait_done("rstu_done_lat", 14);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
